spi_peripheral_word: RTL and testbench

Parametrised SPI peripheral (target) that generalises the fixed Mode-0 byte peripheral to any word width, all four CPOL/CPHA modes, and selectable bit order. It adds a buffered, handshaked transmit path and a receive path with valid/ack handshake and overrun/underrun flags. It sits between the external SPI pins (SCK, CS, COPI, CIPO) and on-chip logic in the `clk` domain. SCK is oversampled; it is never used as a clock.

---
 rtl/spi_peripheral_word.sv | 181 ++++++++++++++++++
 tb/tb_spi_peripheral_word.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral_word.sv
// spi_peripheral_word: oversampled SPI target with configurable word width,
// CPOL/CPHA mode and bit order. Single-entry transmit buffer, receive word
// with valid/ack handshake, sticky overrun/underrun flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | synchronised cs_n high; counter cleared, SCK edges ignored
// ST_ACTIVE | synchronised cs_n low; shifting words in and out
module spi_peripheral_word #(
    parameter int WORD_BITS   = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 cs_n,
    input  logic                 copi,
    output logic                 cipo,
    output logic                 cipo_oe,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_overrun,
    output logic                 tx_underrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
    localparam logic SCK_IDLE = (CPOL != 0);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, copi_sync;
    logic                   sck_s, cs_s, copi_s, sck_d;
    logic                   sck_rise, sck_fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge;
    logic                   active, entering, run;
    logic                   load_ev, shift_adv, sample_ev, word_done, tx_wr;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WORD_BITS-1:0]   rx_sr, rx_next, tx_sr, tx_buf, tx_src;
    logic                   tx_full;

    // Synchronise the asynchronous pins and keep a delayed SCK for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            cs_sync   <= '1;
            copi_sync <= '0;
            sck_d     <= SCK_IDLE;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            sck_d     <= sck_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign lead_edge   = SCK_IDLE ? sck_fall : sck_rise;
    assign trail_edge  = SCK_IDLE ? sck_rise : sck_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode from the synchronised chip select.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!cs_s) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_s)  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign active   = (state_q == ST_ACTIVE);
    assign entering = (state_q == ST_IDLE) && !cs_s;
    // Edges arriving in the same cycle as the cs_n rise belong to an aborted word.
    assign run      = active && !cs_s;
    assign busy     = active;
    assign cipo_oe  = active;

    // Counter at zero on a shift edge marks the start of a new word in both phases.
    assign load_ev   = (run && shift_edge && (bit_cnt == '0)) || ((CPHA == 0) && entering);
    assign shift_adv = run && shift_edge && !load_ev;
    assign sample_ev = run && sample_edge;
    assign word_done = sample_ev && (bit_cnt == LAST_BIT);
    assign tx_wr     = tx_valid && !tx_full;
    assign tx_ready  = ~tx_full;
    assign tx_src    = tx_full ? tx_buf : '0;

    // Receive shift input in the configured bit order.
    always_comb begin
        rx_next = rx_sr;
        if (MSB_FIRST != 0) rx_next = {rx_sr[WORD_BITS-2:0], copi_s};
        else                rx_next = {copi_s, rx_sr[WORD_BITS-1:1]};
    end

    // Transmit buffer: a load uses the pre-write state, so a write never fills it for the current word.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_full     <= 1'b0;
            tx_buf      <= '0;
            tx_underrun <= 1'b0;
        end else begin
            if (load_ev) begin
                if (tx_full) tx_full     <= 1'b0;
                else         tx_underrun <= 1'b1;
            end
            if (tx_wr) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    // Transmit shift register; cipo always presents the current head bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr <= '0;
            cipo  <= 1'b0;
        end else if (load_ev) begin
            tx_sr <= tx_src;
            cipo  <= (MSB_FIRST != 0) ? tx_src[WORD_BITS-1] : tx_src[0];
        end else if (shift_adv) begin
            if (MSB_FIRST != 0) begin
                tx_sr <= tx_sr << 1;
                cipo  <= tx_sr[WORD_BITS-2];
            end else begin
                tx_sr <= tx_sr >> 1;
                cipo  <= tx_sr[1];
            end
        end else if (state_q == ST_IDLE) begin
            tx_sr <= '0;
            cipo  <= 1'b0;
        end
    end

    // Receive path: bit counter, completed word capture and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sr      <= '0;
            bit_cnt    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (sample_ev) begin
                rx_sr   <= rx_next;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (word_done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) rx_overrun <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral_word.sv
// Directed bench for spi_peripheral_word: three instances cover mode 0/8-bit/MSB,
// mode 3/16-bit/MSB and mode 1/8-bit/LSB, sharing SCK and COPI.
module tb_spi_peripheral_word;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset, sck, copi;
    logic [2:0]  cs_n, tx_valid, rx_ack;
    logic [15:0] tx_data;
    logic [2:0]  cipo_v, oe_v, tx_ready_v, rx_valid_v, ovr_v, und_v, busy_v;
    logic [7:0]  rx_data0, rx_data2;
    logic [15:0] rx_data1;
    logic [15:0] miso;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    spi_peripheral_word #(.WORD_BITS(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n[0]), .copi(copi),
        .cipo(cipo_v[0]), .cipo_oe(oe_v[0]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready_v[0]), .rx_data(rx_data0), .rx_valid(rx_valid_v[0]), .rx_ack(rx_ack[0]),
        .rx_overrun(ovr_v[0]), .tx_underrun(und_v[0]), .busy(busy_v[0]));

    spi_peripheral_word #(.WORD_BITS(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n[1]), .copi(copi),
        .cipo(cipo_v[1]), .cipo_oe(oe_v[1]), .tx_data(tx_data), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready_v[1]), .rx_data(rx_data1), .rx_valid(rx_valid_v[1]), .rx_ack(rx_ack[1]),
        .rx_overrun(ovr_v[1]), .tx_underrun(und_v[1]), .busy(busy_v[1]));

    spi_peripheral_word #(.WORD_BITS(8), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_m1 (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n[2]), .copi(copi),
        .cipo(cipo_v[2]), .cipo_oe(oe_v[2]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready_v[2]), .rx_data(rx_data2), .rx_valid(rx_valid_v[2]), .rx_ack(rx_ack[2]),
        .rx_overrun(ovr_v[2]), .tx_underrun(und_v[2]), .busy(busy_v[2]));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] rxd(input int sel);
        case (sel)
            0:       return {8'h00, rx_data0};
            1:       return rx_data1;
            default: return {8'h00, rx_data2};
        endcase
    endfunction

    task automatic tx_write(input int sel, input logic [15:0] w);
        check_val("tx_ready_before_write", tx_ready_v[sel], 1);
        tx_data       = w;
        tx_valid[sel] = 1'b1;
        cyc(1);
        tx_valid[sel] = 1'b0;
    endtask

    task automatic ack(input int sel);
        rx_ack[sel] = 1'b1;
        cyc(1);
        rx_ack[sel] = 1'b0;
    endtask

    task automatic start_frame(input int sel, input bit cpol);
        sck = cpol;
        cyc(H);
        cs_n[sel] = 1'b0;
        cyc(H);
    endtask

    task automatic end_frame(input int sel, input bit cpol);
        cs_n[sel] = 1'b1;
        cyc(H);
        sck = cpol;
        cyc(H);
    endtask

    // Controller side of one word. 'last' holds back the final CPHA=0 trailing edge
    // until after cs_n rises; 'ack_last' pulses rx_ack in the completion cycle.
    task automatic xfer_word(input int sel, input int nbits, input bit cpol, input bit cpha,
                             input bit msb, input logic [15:0] mosi, input bit last,
                             input bit wr_en, input logic [15:0] wr_word, input bit ack_last,
                             output logic [15:0] cap);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = msb ? nbits - 1 - i : i;
            if (wr_en && i == 2) tx_write(sel, wr_word);
            if (!cpha) begin
                copi = mosi[b];
                cyc(H);
                cap[b] = cipo_v[sel];
                sck = ~cpol;
            end else begin
                sck  = ~cpol;
                copi = mosi[b];
                cyc(H);
                cap[b] = cipo_v[sel];
                sck = cpol;
            end
            if (ack_last && i == nbits - 1) begin
                cyc(2);
                rx_ack[sel] = 1'b1;
                cyc(1);
                rx_ack[sel] = 1'b0;
                cyc(H - 3);
            end else begin
                cyc(H);
            end
            if (!cpha && !(last && i == nbits - 1)) sck = cpol;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs_n = 3'b111; sck = 1'b0; copi = 1'b0;
        tx_valid = '0; rx_ack = '0; tx_data = '0;
        cyc(4);
        reset = 1'b0;
        cyc(2);
        check_val("rst_tx_ready", tx_ready_v[0], 1);
        check_val("rst_busy", busy_v[0], 0);
        check_val("rst_cipo_oe", oe_v[0], 0);
        check_val("rst_rx_valid", rx_valid_v[0], 0);
        check_val("rst_flags", {ovr_v[0], und_v[0]}, 0);
        check_val("rst_cipo", cipo_v[0], 0);

        // Mode 0: preload 0xA5, receive 0x3C
        tx_write(0, 16'h00A5);
        check_val("m0_tx_ready_full", tx_ready_v[0], 0);
        start_frame(0, 1'b0);
        check_val("m0_busy", busy_v[0], 1);
        check_val("m0_cipo_oe", oe_v[0], 1);
        check_val("m0_tx_ready_loaded", tx_ready_v[0], 1);
        xfer_word(0, 8, 1'b0, 1'b0, 1'b1, 16'h003C, 1'b1, 1'b0, 16'h0, 1'b0, miso);
        end_frame(0, 1'b0);
        check_val("m0_cipo_word", miso, 16'h00A5);
        check_val("m0_rx_data", rxd(0), 16'h003C);
        check_val("m0_rx_valid", rx_valid_v[0], 1);
        check_val("m0_no_overrun", ovr_v[0], 0);
        check_val("m0_no_underrun", und_v[0], 0);
        check_val("m0_idle_busy", busy_v[0], 0);
        ack(0);
        check_val("m0_ack_clears", rx_valid_v[0], 0);

        // Mode 3, 16-bit: two words in one frame, write during word 1
        tx_write(1, 16'h1234);
        start_frame(1, 1'b1);
        check_val("m3_busy", busy_v[1], 1);
        check_val("m3_cipo_oe", oe_v[1], 1);
        xfer_word(1, 16, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b0, 1'b1, 16'hBEEF, 1'b0, miso);
        check_val("m3_cipo_word1", miso, 16'h1234);
        check_val("m3_rx_data1", rxd(1), 16'hCAFE);
        check_val("m3_rx_valid1", rx_valid_v[1], 1);
        check_val("m3_tx_ready_buffered", tx_ready_v[1], 0);
        ack(1);
        check_val("m3_ack_clears", rx_valid_v[1], 0);
        xfer_word(1, 16, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b0, 16'h0, 1'b0, miso);
        check_val("m3_cipo_word2", miso, 16'hBEEF);
        check_val("m3_rx_data2", rxd(1), 16'h0F0F);
        check_val("m3_rx_valid2", rx_valid_v[1], 1);
        check_val("m3_flags", {ovr_v[1], und_v[1]}, 0);
        ack(1);
        end_frame(1, 1'b1);

        // Mode 1, LSB first, no preload; second word acked in its completion cycle
        start_frame(2, 1'b0);
        check_val("m1_busy", busy_v[2], 1);
        check_val("m1_cipo_oe", oe_v[2], 1);
        xfer_word(2, 8, 1'b0, 1'b1, 1'b0, 16'h0081, 1'b0, 1'b0, 16'h0, 1'b0, miso);
        check_val("m1_cipo_zero", miso, 16'h0000);
        check_val("m1_underrun", und_v[2], 1);
        check_val("m1_rx_data", rxd(2), 16'h0081);
        check_val("m1_tx_ready", tx_ready_v[2], 1);
        xfer_word(2, 8, 1'b0, 1'b1, 1'b0, 16'h0042, 1'b1, 1'b0, 16'h0, 1'b1, miso);
        check_val("m1_same_cycle_ack_valid", rx_valid_v[2], 1);
        check_val("m1_same_cycle_ack_data", rxd(2), 16'h0042);
        check_val("m1_same_cycle_ack_no_ovr", ovr_v[2], 0);
        end_frame(2, 1'b0);

        // Mode 0 overrun: 0x11 then 0x22 without ack
        start_frame(0, 1'b0);
        xfer_word(0, 8, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h0, 1'b0, miso);
        xfer_word(0, 8, 1'b0, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b0, 16'h0, 1'b0, miso);
        end_frame(0, 1'b0);
        check_val("ovr_flag", ovr_v[0], 1);
        check_val("ovr_rx_data", rxd(0), 16'h0022);
        check_val("ovr_underrun", und_v[0], 1);
        ack(0);

        // Abort after 5 bits, then full frame 0x5A with a buffered word
        tx_write(0, 16'h000F);
        start_frame(0, 1'b0);
        tx_write(0, 16'h00C3);
        xfer_word(0, 5, 1'b0, 1'b0, 1'b1, 16'h001F, 1'b1, 1'b0, 16'h0, 1'b0, miso);
        end_frame(0, 1'b0);
        check_val("abort_partial_cipo", miso, 16'h0001);
        check_val("abort_no_rx_valid", rx_valid_v[0], 0);
        check_val("abort_buffer_kept", tx_ready_v[0], 0);
        start_frame(0, 1'b0);
        xfer_word(0, 8, 1'b0, 1'b0, 1'b1, 16'h005A, 1'b1, 1'b0, 16'h0, 1'b0, miso);
        end_frame(0, 1'b0);
        check_val("abort_next_cipo", miso, 16'h00C3);
        check_val("abort_next_rx_data", rxd(0), 16'h005A);
        check_val("abort_next_rx_valid", rx_valid_v[0], 1);

        // Reset mid-word
        tx_write(0, 16'h0077);
        start_frame(0, 1'b0);
        tx_write(0, 16'h0066);
        xfer_word(0, 3, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0, 1'b0, miso);
        check_val("pre_reset_cipo", cipo_v[0], 1);
        reset = 1'b1;
        cyc(1);
        check_val("mid_rst_cipo", cipo_v[0], 0);
        check_val("mid_rst_cipo_oe", oe_v[0], 0);
        check_val("mid_rst_tx_ready", tx_ready_v[0], 1);
        check_val("mid_rst_rx_data", rxd(0), 16'h0000);
        check_val("mid_rst_rx_valid", rx_valid_v[0], 0);
        check_val("mid_rst_overrun", ovr_v[0], 0);
        check_val("mid_rst_underrun", und_v[0], 0);
        check_val("mid_rst_busy", busy_v[0], 0);
        cs_n[0] = 1'b1;
        sck = 1'b0;
        cyc(4);
        reset = 1'b0;
        cyc(H);
        start_frame(0, 1'b0);
        xfer_word(0, 8, 1'b0, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, 16'h0, 1'b0, miso);
        end_frame(0, 1'b0);
        check_val("post_rst_rx_data", rxd(0), 16'h0099);
        check_val("post_rst_rx_valid", rx_valid_v[0], 1);
        check_val("post_rst_cipo", miso, 16'h0000);
        check_val("post_rst_underrun", und_v[0], 1);
        check_val("post_rst_overrun", ovr_v[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
